ms_sync_accumulator: RTL
========================

Name: ms_sync_accumulator

Overview:
- Parametrised multi-channel slave-to-master relay built on the two-section (SECTION_A / SECTION_B) control style.
- Arbitrates NUM_CH slave inputs, each qualified by its own sync strobe, using round-robin.
- Accumulates the granted value into an internal register and publishes the running total on a master output with a one-cycle valid pulse.
- Sits between several slave producers and one master consumer in the generated master/slave test designs.

Parameters:
- DATA_W, 32, width of each slave datum, the accumulator and s_out.
- NUM_CH, 4, number of slave channels (2..16).
- INIT_VAL, 1337, accumulator value loaded at reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_in  in  NUM_CH*DATA_W  slave data; channel i occupies bits [i*DATA_W +: DATA_W].
- s_in_sync  in  NUM_CH  per-channel data-valid strobe.
- s_out  out  DATA_W  published accumulator value.
- s_out_valid  out  1  one-cycle pulse; s_out is new this cycle.
- s_out_ch  out  $clog2(NUM_CH)  channel that produced the current s_out.
- busy  out  1  high while in SECTION_B.

Behaviour:
- Reset (async, immediate):
  - section=SECTION_A, val_signal=INIT_VAL, ptr=0.
  - s_out=0, s_out_valid=0, s_out_ch=0, busy=0.
- SECTION_A (accept):
  - Grant = first channel with s_in_sync=1, searching ptr, ptr+1, ... modulo NUM_CH.
  - On a grant at edge k: val_signal <= val_signal + s_in[grant], truncated to DATA_W (wraps mod 2^DATA_W); latch grant into cur_ch; section <= SECTION_B.
  - No sync asserted: hold all state; ptr does not move.
- SECTION_B (publish):
  - At edge k+1: s_out <= val_signal, s_out_ch <= cur_ch, s_out_valid <= 1 for exactly one cycle.
  - Same edge: ptr <= (cur_ch+1) mod NUM_CH; section <= SECTION_A.
  - Latency: sync sampled at edge k gives s_out_valid high in the cycle after edge k+1.
- s_in_sync is ignored while in SECTION_B:
  - A sync held high is served at the next SECTION_A evaluation.
  - A single-cycle pulse arriving in SECTION_B is dropped (documented, not an error).
- Maximum throughput is one accepted datum per 2 cycles.
- busy = (section==SECTION_B), registered alongside section.
- Simultaneous syncs: exactly one channel is granted, in round-robin order. Starvation-free: a continuously held sync is granted within NUM_CH accepts.
- ptr wraps from NUM_CH-1 to 0.
- Reset mid-SECTION_B: the pending publish is discarded, no valid pulse, all state returns to reset values.
- s_out holds its last value between pulses.

Optional Feature:
- Macro: MS_SYNC_ACC_SATURATE_EN.
- Defined: the add is unsigned saturating; val_signal clamps at 2^DATA_W-1 and stays there until reset.
- Undefined: modulo wrap-around as above.

Decomposition:
- Package ms_sync_accumulator_types holds:
  - typedef enum {SECTION_A, SECTION_B} MsSyncAcc_SECTIONS;
  - localparam DEFAULT_INIT_VAL = 1337.
- One sub-module, ms_rr_arbiter (NUM_CH): combinational round-robin grant.
  - Inputs: req vector and ptr.
  - Outputs: grant_valid and grant index.
- Sequencing, accumulator and output registers stay in the top module.

Test Plan:
- Reset then single sync: ch0 sync with s_in[0]=3 at edge k -> s_out_valid in the cycle after edge k+1, s_out=1340, s_out_ch=0.
- All four syncs held, each s_in=1 -> grants in order 0,1,2,3,0; s_out 1338,1339,1340,1341,1342; valid every 2nd cycle.
- Wrap: DATA_W=8, INIT_VAL=250, ch2 adds 10 -> s_out=4. With MS_SYNC_ACC_SATURATE_EN -> s_out=255, and stays 255 after a further add of 1.
- Single-cycle sync pulse on ch1 during SECTION_B -> no grant, no extra valid pulse, val_signal unchanged.
- Assert rst in SECTION_B after a grant -> s_out_valid never pulses; s_out=0, busy=0; next accept starts from 1337 and ptr=0.
- Fairness: ch3 held continuously while ch0 re-asserts every cycle -> ch3 granted no later than the 2nd accept.

Source files
------------

// File: rtl/ms_sync_accumulator_pkg.sv
// Shared types and defaults for the slave-to-master sync accumulator.
// The section enum is shared by the top module and by anything that needs to decode busy.
package ms_sync_accumulator_types;

    typedef enum logic {
        SECTION_A = 1'b0,
        SECTION_B = 1'b1
    } MsSyncAcc_SECTIONS;

    localparam int DEFAULT_INIT_VAL = 1337;

endpackage

// File: rtl/ms_sync_accumulator_rr_arbiter.sv
// Combinational round-robin grant: the first requester found when searching
// from ptr upward, wrapping modulo NUM_CH.
module ms_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              grant_valid,
    output logic [PTR_W-1:0]  grant
);

    always_comb begin
        logic [PTR_W:0]   sum_idx;
        logic [PTR_W-1:0] idx;
        grant_valid = 1'b0;
        grant       = '0;
        sum_idx     = '0;
        idx         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // One spare bit holds ptr+i before the modulo fold.
            sum_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum_idx >= (PTR_W+1)'(NUM_CH)) begin
                sum_idx = sum_idx - (PTR_W+1)'(NUM_CH);
            end
            idx = sum_idx[PTR_W-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx;
            end
        end
    end

endmodule

// File: rtl/ms_sync_accumulator.sv
// Multi-channel sync-qualified accumulator relaying slave data to one master.
// Build option MS_SYNC_ACC_SATURATE_EN makes the add unsigned-saturating.
//
// state     | meaning
// SECTION_A | accept: grant one synced channel round-robin and add its datum
// SECTION_B | publish: drive s_out/s_out_ch with a one-cycle s_out_valid, advance ptr
module ms_sync_accumulator
    import ms_sync_accumulator_types::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                NUM_CH   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(DEFAULT_INIT_VAL),
    parameter int                PTR_W    = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] s_in,
    input  logic [NUM_CH-1:0]        s_in_sync,
    output logic [DATA_W-1:0]        s_out,
    output logic                     s_out_valid,
    output logic [PTR_W-1:0]         s_out_ch,
    output logic                     busy
);

    MsSyncAcc_SECTIONS section;
    logic [DATA_W-1:0] val_signal;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  cur_ch;

    logic              grant_valid;
    logic [PTR_W-1:0]  grant;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] acc_next;
    logic [PTR_W-1:0]  ptr_next;

    ms_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req         (s_in_sync),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == PTR_W'(i)) begin
                sel_data = s_in[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MS_SYNC_ACC_SATURATE_EN
    logic [DATA_W:0] sum_ext;
    always_comb begin
        sum_ext  = {1'b0, val_signal} + {1'b0, sel_data};
        acc_next = sum_ext[DATA_W] ? {DATA_W{1'b1}} : sum_ext[DATA_W-1:0];
    end
`else
    always_comb begin
        acc_next = val_signal + sel_data;
    end
`endif

    always_comb begin
        if (cur_ch == PTR_W'(NUM_CH-1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = cur_ch + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            section     <= SECTION_A;
            val_signal  <= INIT_VAL;
            ptr         <= '0;
            cur_ch      <= '0;
            s_out       <= '0;
            s_out_valid <= 1'b0;
            s_out_ch    <= '0;
            busy        <= 1'b0;
        end else begin
            s_out_valid <= 1'b0;
            case (section)
                SECTION_A: begin
                    if (grant_valid) begin
                        val_signal <= acc_next;
                        cur_ch     <= grant;
                        section    <= SECTION_B;
                        busy       <= 1'b1;
                    end
                end
                SECTION_B: begin
                    // Syncs are not looked at here; held ones are served next accept.
                    s_out       <= val_signal;
                    s_out_ch    <= cur_ch;
                    s_out_valid <= 1'b1;
                    ptr         <= ptr_next;
                    section     <= SECTION_A;
                    busy        <= 1'b0;
                end
                default: begin
                    section <= SECTION_A;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
